// File: rtl/receive.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err strobes.
// Optional RECEIVE_MAJORITY_EN: 3-sample majority vote per sample point (needs CLKS_PER_BIT >= 8).
module receive #(
  parameter int unsigned CLKS_PER_BIT = 10000
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       UART_Rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [15:0] target;
  logic        sample_tick;
  logic        sample_bit;
  logic [15:0] cnt_restart;

`ifdef RECEIVE_MAJORITY_EN
  logic s0;
  logic s1;

  // Decision lands one count late; restarting at 1 keeps later sample points on the original grid.
  always_comb begin
    target      = (state == START) ? HALF_M1 : BIT_M1;
    sample_tick = (cnt == target + 16'd1);
    sample_bit  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    cnt_restart = 16'd1;
  end
`else
  always_comb begin
    target      = (state == START) ? HALF_M1 : BIT_M1;
    sample_tick = (cnt == target);
    sample_bit  = rx_s;
    cnt_restart = '0;
  end
`endif

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef RECEIVE_MAJORITY_EN
      s0        <= 1'b1;
      s1        <= 1'b1;
`endif
    end else begin
      rx_m      <= UART_Rx;
      rx_s      <= rx_m;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef RECEIVE_MAJORITY_EN
      if (cnt == target - 16'd1) s0 <= rx_s;
      if (cnt == target)         s1 <= rx_s;
`endif
      unique case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (sample_tick) begin
            if (!sample_bit) begin
              state <= DATA;
              cnt   <= cnt_restart;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (sample_tick) begin
            shreg[idx] <= sample_bit;
            cnt        <= cnt_restart;
            if (idx == 3'd7) begin
              state <= STOP;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (sample_tick) begin
            cnt <= '0;
            if (sample_bit) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/receive.md
# receive

UART receiver paired with the `Transmit` block: deserialises one 8N1 frame (start 0, 8 data bits LSB first, stop 1) from the `UART_Rx` line into a byte, with `Clk_100M` as the only clock. It reports each good byte with a one-cycle `valid` strobe and each bad stop bit with `frame_err`. It sits between the board UART pin and the command/data consumer, using the same bit period as `Transmit` (10000 clocks, 10 kbaud at 100 MHz).

## Interface
- `CLKS_PER_BIT`, default 10000: clocks per bit. Legal range 4..65535. Define `HALF = CLKS_PER_BIT/2`, integer floor.
- `Clk_100M` input, 1 bit: system clock; all logic is on the rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `UART_Rx` input, 1 bit: asynchronous serial line, idle high.
- `data` output, 8 bits: last correctly received byte. Held until the next good frame.
- `valid` output, 1 bit: one-cycle pulse when `data` is updated.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples 0.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- Input sync: two-flop synchroniser on `UART_Rx`, both flops reset to 1. All decisions use the synchronised line `rx_s`.
- Counters:
  - `cnt` is 16 bits and cleared on every state entry and after every sample.
  - `idx` is 3 bits and counts data bits.
- States:
  - IDLE: when `rx_s` is 0, go to START.
  - START: at `cnt == HALF-1`, sample `rx_s`.
    - If 0: go to DATA and clear `cnt`.
    - If 1: glitch; go to IDLE with no output.
  - DATA: at `cnt == CLKS_PER_BIT-1`, sample `rx_s` into shift register bit `idx`, LSB first.
    - After `idx` 7, go to STOP.
  - STOP: at `cnt == CLKS_PER_BIT-1`, sample the stop bit.
    - If 1: `data` <= shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` is 1 (break/line-low condition), then go to IDLE. A frame is never started from a line that has stayed low since the previous frame.
- Returning to IDLE at mid-stop-bit lets the block accept back-to-back frames with zero idle time.
- `valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data` = 8'h00, `valid` = 0, `frame_err` = 0, `busy` = 0, state = IDLE, `cnt` = 0, `idx` = 0, synchroniser = 1.
- Reset asserted mid-frame:
  - All of the above take effect on the next edge.
  - A partial byte is discarded; no `valid` or `frame_err` is emitted.
- Latency from the `UART_Rx` falling edge (edge 0) to `valid`/`frame_err` high:
  - 2 cycles for the synchroniser + 1 cycle for START entry + `HALF` + 9×`CLKS_PER_BIT`.
  - Default: 95003 cycles.
- `busy` rises 3 cycles after the falling edge.
- `busy` falls in the same cycle that `valid` rises. After a framing error it falls 1 cycle after `rx_s` returns high.
- Sample points: bit n (start = 0, stop = 9) is sampled `HALF` + n×`CLKS_PER_BIT` cycles after START entry.
- No input backpressure: a consumer that misses the `valid` pulse loses only the strobe; `data` remains readable until the next good frame.

## Configuration
- `RECEIVE_MAJORITY_EN` defined:
  - Each sample point (start, data, stop) takes the majority of `rx_s` at `cnt` = target-1, target and target+1.
  - The decision is registered at target+1, so all latencies above grow by 1 cycle.
  - Requires `CLKS_PER_BIT` >= 8.
- Undefined: single sample at the target count; latencies exactly as in Timing.

## Test plan
- Reset, then hold `UART_Rx` = 1 for 30000 cycles → `valid` = `frame_err` = `busy` = 0 throughout, `data` = 8'h00.
- Send frame 8'hA5 at 10000 clocks/bit → single `valid` pulse exactly 95003 cycles after the start edge, `data` = 8'hA5, `busy` = 0 afterwards.
- Low glitch of 2000 cycles on an idle line → no `valid`, no `frame_err`, `busy` high for about 5000 cycles, then back to IDLE.
- Frame 8'h3C with stop bit 0, line held low 20000 further cycles, then high → one `frame_err` pulse, `data` unchanged, `busy` stays high until the line rises, no spurious frame detected.
- Frames 8'h00 then 8'hFF back-to-back, no idle gap → two `valid` pulses exactly 100000 cycles apart, `data` = 8'h00 then 8'hFF.
- Reset asserted at bit 4 of a frame, then a full frame 8'h81 sent → no output from the aborted frame, then `valid` with `data` = 8'h81. With `RECEIVE_MAJORITY_EN`, a 1-cycle inverted spike at the bit-3 sample point of 8'h81 still yields `data` = 8'h81.
